// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared systolic-array types and the WY->WO saturation helper
package acc_drain_pkg;
  typedef enum logic {IDLE, DRAIN} state_t;
  // Clip a sign-extended accumulator value into a signed wo-bit range.
  // The PE output path can reuse this by sign-extending into 64 bits.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int wo);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wo - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/acc_drain.sv
// acc_drain: serialises a parallel block of R accumulator words into a saturated AXI-Stream
// Ports: clk, rstn (sync, active-low); s_valid/s_ready/s_data take a block of R signed WY-bit
// words; m_valid/m_ready/m_data/m_last emit WO-bit saturated words, m_last on element R-1;
// sat_flag is sticky once any emitted word was clipped.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int R  = 4,
  parameter int WY = 16,
  parameter int WO = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [R*WY-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WO-1:0]   m_data,
  output logic            m_last,
  output logic            sat_flag
);
  localparam int CW = R > 1 ? $clog2(R) : 1;
  state_t state, state_n;
  logic signed [WY-1:0] buf_q [R];
  logic [CW-1:0] cnt;
  logic signed [63:0] ext, clip;
  logic load, hs, clipped;
  always_comb begin
    ext = 64'(buf_q[0]);
    clip = sat_clip(ext, WO);
    clipped = clip != ext;
    m_data = clip[WO-1:0];
    m_valid = state == DRAIN;
    m_last = m_valid && cnt == CW'(R - 1);
    hs = m_valid && m_ready;
    // The last handshake frees the buffer in the same cycle, so a new block can load with no bubble.
    s_ready = rstn && (state == IDLE || (hs && m_last));
    load = s_valid && s_ready;
    state_n = load ? DRAIN : (hs && m_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      sat_flag <= 1'b0;
      for (int i = 0; i < R; i++) buf_q[i] <= '0;
    end else begin
      state <= state_n;
      if (hs && clipped) sat_flag <= 1'b1;
      if (load) begin
        for (int i = 0; i < R; i++) buf_q[i] <= s_data[WY*i +: WY];
        cnt <= '0;
      end else if (hs) begin
        // Shift toward element 0 so the output always reads entry 0.
        for (int i = 0; i < R - 1; i++) buf_q[i] <= buf_q[i+1];
        buf_q[R-1] <= '0;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: randomized and directed checks of acc_drain against a queue-based reference model
module tb_acc_drain;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic [63:0] s_data = '0;
  logic s_ready, m_valid, m_last, sat_flag;
  logic [7:0] m_data;
  logic s_valid1 = 1'b0, m_ready1 = 1'b0;
  logic [15:0] s_data1 = '0;
  logic s_ready1, m_valid1, m_last1, sat_flag1;
  logic [7:0] m_data1;
  int checks = 0;
  int failures = 0;
  int q[$];
  bit sat_exp = 1'b0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  acc_drain #(.R(4), .WY(16), .WO(8)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .sat_flag(sat_flag)
  );

  acc_drain #(.R(1), .WY(16), .WO(8)) dut1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1), .sat_flag(sat_flag1)
  );

  function automatic int sat8(input int v);
    return v > 127 ? 127 : (v < -128 ? -128 : v);
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // One cycle: drive inputs, compare against the model's pending-word queue, then advance the model.
  task automatic step(input bit sv, input logic [63:0] d, input bit mr);
    logic ev, er, el;
    logic [7:0] ed;
    @(negedge clk);
    s_valid = sv;
    s_data = d;
    m_ready = mr;
    #1;
    ev = q.size() > 0;
    er = q.size() == 0 || (mr && q.size() == 1);
    checks++;
    if (m_valid !== ev) begin failures++; $display("FAIL m_valid got=%b exp=%b", m_valid, ev); end
    checks++;
    if (s_ready !== er) begin failures++; $display("FAIL s_ready got=%b exp=%b", s_ready, er); end
    checks++;
    if (sat_flag !== sat_exp) begin failures++; $display("FAIL sat_flag got=%b exp=%b", sat_flag, sat_exp); end
    if (ev) begin
      ed = 8'(sat8(q[0]));
      el = q.size() == 1;
      checks++;
      if (m_data !== ed) begin failures++; $display("FAIL m_data got=%0d exp=%0d", $signed(m_data), $signed(ed)); end
      checks++;
      if (m_last !== el) begin failures++; $display("FAIL m_last got=%b exp=%b", m_last, el); end
      if (mr) begin
        if (sat8(q[0]) != q[0]) sat_exp = 1'b1;
        void'(q.pop_front());
        hs_cnt++;
      end
    end
    if (sv && er) for (int i = 0; i < 4; i++) q.push_back(int'($signed(d[16*i +: 16])));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    s_valid = 1'b1;
    s_valid1 = 1'b1;
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++;
    if (s_ready1 !== 1'b0) begin failures++; $display("FAIL rst_s_ready1 got=%b exp=0", s_ready1); end
    @(negedge clk);
    rstn = 1'b1;
    s_valid = 1'b0;
    s_valid1 = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++;
    if (m_data !== 8'd0) begin failures++; $display("FAIL rst_m_data got=%0d exp=0", m_data); end
    checks++;
    if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    checks++;
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL rst_sat_flag got=%b exp=0", sat_flag); end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_release_s_ready got=%b exp=1", s_ready); end
    checks++;
    if (m_valid1 !== 1'b0 || m_last1 !== 1'b0) begin
      failures++; $display("FAIL rst_dut1 m_valid1=%b m_last1=%b exp=0,0", m_valid1, m_last1);
    end
    q.delete();
    sat_exp = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    step(1'b1, pack4(3, -2, 100, -100), 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    checks++;
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", sat_flag); end
  endtask

  task automatic test_saturate();
    step(1'b1, pack4(200, -300, 127, -128), 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);
    checks++;
    if (sat_flag !== 1'b1) begin failures++; $display("FAIL saturate_sticky got=%b exp=1", sat_flag); end
  endtask

  task automatic test_stall();
    step(1'b1, pack4(11, -22, 33, -44), 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (3) step(1'b1, pack4(1, 2, 3, 4), 1'b0);
    repeat (4) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int h0;
    step(1'b1, pack4(5, 6, 7, 8), 1'b1);
    h0 = hs_cnt;
    repeat (4) step(1'b1, pack4(-9, 10, -11, 12), 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    checks++;
    if (hs_cnt - h0 !== 8) begin failures++; $display("FAIL b2b_handshakes got=%0d exp=8", hs_cnt - h0); end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, pack4(300, 1, 2, 3), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b1, pack4(21, 22, 23, 24), 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(1)),
           pack4(int'($urandom_range(600)) - 300, int'($urandom_range(600)) - 300,
                 int'($urandom_range(600)) - 300, int'($urandom_range(600)) - 300),
           1'($urandom_range(3) != 0));
    end
    repeat (6) step(1'b0, '0, 1'b1);
  endtask

  task automatic test_r1();
    int prev, v;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v = (k == 2) ? 250 : int'($urandom_range(200)) - 100;
      s_valid1 = 1'b1;
      s_data1 = 16'(v);
      m_ready1 = 1'b1;
      #1;
      checks++;
      if (s_ready1 !== 1'b1) begin failures++; $display("FAIL r1_s_ready k=%0d got=%b exp=1", k, s_ready1); end
      if (k > 0) begin
        checks++;
        if (m_valid1 !== 1'b1 || m_last1 !== 1'b1) begin
          failures++; $display("FAIL r1_valid_last k=%0d got=%b%b exp=11", k, m_valid1, m_last1);
        end
        checks++;
        if (m_data1 !== 8'(sat8(prev))) begin
          failures++; $display("FAIL r1_data k=%0d got=%0d exp=%0d", k, $signed(m_data1), sat8(prev));
        end
      end
      prev = v;
    end
    @(negedge clk);
    s_valid1 = 1'b0;
    #1;
    checks++;
    if (m_valid1 !== 1'b1 || m_last1 !== 1'b1 || m_data1 !== 8'(sat8(prev))) begin
      failures++; $display("FAIL r1_tail got=%b%b %0d exp=11 %0d", m_valid1, m_last1, $signed(m_data1), sat8(prev));
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_valid1 !== 1'b0) begin failures++; $display("FAIL r1_idle got=%b exp=0", m_valid1); end
    checks++;
    if (sat_flag1 !== 1'b1) begin failures++; $display("FAIL r1_sat got=%b exp=1", sat_flag1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_r1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 SHALL have parameter R, default 4, meaning accumulator words per block (R >= 1).
REQ-002 SHALL have parameter WY, default 16, meaning input accumulator word width, signed.
REQ-003 SHALL have parameter WO, default 8, meaning output word width, signed, WO <= WY.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  parallel block of R accumulator results available.
REQ-007 SHALL have port s_ready  output  1  block accepted on s_valid && s_ready.
REQ-008 SHALL have port s_data  input  R*WY  element i at bits [WY*i +: WY].
REQ-009 SHALL have port m_valid  output  1  AXI-Stream master valid.
REQ-010 SHALL have port m_ready  input  1  AXI-Stream master ready.
REQ-011 SHALL have port m_data  output  WO  saturated output word.
REQ-012 SHALL have port m_last  output  1  high on element R-1 of each block.
REQ-013 SHALL have port sat_flag  output  1  sticky, set when any emitted word was clipped.

Function
REQ-014 SHALL implement two states: IDLE (buffer empty) and DRAIN (buffer holds undelivered words).
REQ-015 SHALL drive s_ready = (state==IDLE) || (m_valid && m_ready && m_last), combinationally.
REQ-016 SHALL, on load (s_valid && s_ready), capture all of s_data into the buffer, clear the element counter to 0, and enter DRAIN.
REQ-017 SHALL present element 0 of a loaded block with m_valid=1 in the cycle after the load edge (latency 1).
REQ-018 SHALL emit elements in order 0..R-1, advancing one element per m_valid && m_ready handshake.
REQ-019 SHALL hold m_data, m_last and m_valid stable while m_valid && !m_ready.
REQ-020 SHALL assert m_last exactly when the counter equals R-1; with R=1, every word is last.
REQ-021 SHALL, on the handshake of the last word with s_valid high, load the next block in the same cycle, giving zero bubble cycles between blocks.
REQ-022 SHALL, on the handshake of the last word with s_valid low, return to IDLE with m_valid=0 the next cycle.
REQ-023 SHALL saturate: values > 2^(WO-1)-1 become 2^(WO-1)-1, values < -2^(WO-1) become -2^(WO-1), and other values pass unchanged (low WO bits); with WO==WY, no clipping occurs.
REQ-024 SHALL set sat_flag on the handshake cycle of any clipped word; sat_flag clears only on reset.
REQ-025 SHALL ignore s_data while s_ready=0; input never overwrites undelivered words.
REQ-026 SHALL never emit m_valid in IDLE.

Reset
REQ-027 SHALL, when rstn=0 at a clock edge, set state IDLE, counter 0, buffer 0, m_valid 0, m_last 0, m_data 0, sat_flag 0.
REQ-028 SHALL force s_ready=0 while rstn=0.
REQ-029 SHALL, on reset mid-block, discard remaining words with no partial m_last; the first block after reset starts at element 0.

Structure
REQ-030 SHALL place the saturation bounds function (WY to WO clip) in the shared systolic-array package, so that the PE output path can reuse it.
REQ-031 SHALL have no sub-module; buffer, counter and FSM SHALL reside in acc_drain, with the buffer implemented as an R-entry shift register shifting toward element 0.

Verification
REQ-032 SHALL cover: R=4, WO=8, load {3,-2,100,-100}, m_ready=1 -> m_data 3,-2,100,-100 on cycles 1-4, m_last on cycle 4 only, sat_flag=0.
REQ-033 SHALL cover: load {200,-300,127,-128}, WY=16 -> 127,-128,127,-128 emitted, sat_flag=1 after the first handshake.
REQ-034 SHALL cover: m_ready low for 3 cycles on element 1 -> element 1 held stable for 4 cycles, no element skipped.
REQ-035 SHALL cover: two blocks with s_valid held high -> 8 consecutive handshake cycles with no bubble, s_ready high only on the cycle of the first block's last handshake.
REQ-036 SHALL cover: rstn=0 after element 2 -> next cycle m_valid=0, s_ready=1 after release, next block starts at element 0, sat_flag=0.
REQ-037 SHALL cover: R=1 -> every word m_last=1, and back-to-back loads accepted each cycle with m_ready=1.
